// File: rtl/reg_arith_pkg.sv
// reg_arith_pkg: shared op-code encoding and default jump offset for reg_arith_bank
package reg_arith_pkg;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_INCR = 3'd1,
    OP_DECR = 3'd2,
    OP_LOAD = 3'd3,
    OP_JIZR = 3'd4,
    OP_JNZR = 3'd5,
    OP_DJNZ = 3'd6,
    OP_RSV  = 3'd7
  } op_e;
  localparam int ZERO_OFF_DEF = 16;
endpackage

// File: rtl/reg_arith_alu.sv
// reg_arith_alu: combinational inc/dec, jump-target adder, offset select and flags; saturating when REG_ARITH_SAT_EN is defined
module reg_arith_alu
  import reg_arith_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int OFFW     = 3,
  parameter int ZERO_OFF = ZERO_OFF_DEF
) (
  input  logic [2:0]       i_code,
  input  logic [WIDTH-1:0] i_cur,
  input  logic [OFFW-1:0]  i_v,
  input  logic [WIDTH-1:0] i_pc,
  output logic             o_we,
  output logic [WIDTH-1:0] o_next,
  output logic [WIDTH-1:0] o_data,
  output logic             o_taken,
  output logic             o_zero,
  output logic             o_flag
);
  op_e              w_op;
  logic             w_at_max, w_at_min, w_dj_flag;
  logic [WIDTH:0]   w_inc, w_dec, w_jmp;
  logic [WIDTH-1:0] w_inc_v, w_dec_v, w_off;
  assign w_op     = op_e'(i_code);
  assign w_at_max = &i_cur;
  assign w_at_min = ~|i_cur;
  assign w_inc    = {1'b0, i_cur} + 1'b1;
  assign w_dec    = {1'b0, i_cur} - 1'b1;
`ifdef REG_ARITH_SAT_EN
  assign w_inc_v   = w_at_max ? i_cur : w_inc[WIDTH-1:0];
  assign w_dec_v   = w_at_min ? i_cur : w_dec[WIDTH-1:0];
  assign w_dj_flag = w_at_min;
`else
  assign w_inc_v   = w_inc[WIDTH-1:0];
  assign w_dec_v   = w_dec[WIDTH-1:0];
  assign w_dj_flag = 1'b0;
`endif
  assign w_off   = (i_v != '0) ? WIDTH'(i_v) : WIDTH'(ZERO_OFF);
  assign o_taken = (w_op == OP_JIZR) ? w_at_min :
                   (w_op == OP_JNZR) ? !w_at_min :
                   (w_op == OP_DJNZ) ? |w_dec_v : 1'b0;
  assign w_jmp   = {1'b0, i_pc} + {1'b0, o_taken ? w_off : WIDTH'(1)};
  // Per-op register update, result value and flag; zero reflects the post-op register
  always_comb begin
    o_we   = 1'b0;
    o_next = i_cur;
    o_data = '0;
    o_flag = 1'b0;
    case (w_op)
      OP_INCR: begin o_we = 1'b1; o_next = w_inc_v; o_data = w_inc_v; o_flag = w_at_max; end
      OP_DECR: begin o_we = 1'b1; o_next = w_dec_v; o_data = w_dec_v; o_flag = w_at_min; end
      OP_LOAD: begin o_we = 1'b1; o_next = i_pc; o_data = i_pc; end
      OP_JIZR, OP_JNZR: begin o_data = w_jmp[WIDTH-1:0]; o_flag = w_jmp[WIDTH]; end
      OP_DJNZ: begin o_we = 1'b1; o_next = w_dec_v; o_data = w_jmp[WIDTH-1:0]; o_flag = w_jmp[WIDTH] | w_dj_flag; end
      default: o_we = 1'b0;
    endcase
    o_zero = (w_op != OP_NOP) && (w_op != OP_RSV) && ~|o_next;
  end
endmodule

// File: rtl/reg_arith_bank.sv
// reg_arith_bank: counter register bank with 1-cycle arithmetic/jump ops and a single-entry result buffer (REG_ARITH_SAT_EN selects saturating arithmetic)
module reg_arith_bank
  import reg_arith_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NREGS    = 4,
  parameter int OFFW     = 3,
  parameter int ZERO_OFF = ZERO_OFF_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [2:0]               op_code,
  input  logic [$clog2(NREGS)-1:0] op_sel,
  input  logic [OFFW-1:0]          op_v,
  input  logic [WIDTH-1:0]         op_data,
  input  logic                     res_ready,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic [$clog2(NREGS)-1:0] res_sel,
  output logic                     res_taken,
  output logic                     res_zero,
  output logic                     res_flag
);
  localparam int SELW = $clog2(NREGS);
  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_res_valid, r_res_taken, r_res_zero, r_res_flag;
  logic [WIDTH-1:0] r_res_data;
  logic [SELW-1:0]  r_res_sel;
  logic             w_acc, w_in_range, w_we, w_taken, w_zero, w_flag;
  logic [WIDTH-1:0] w_cur, w_next, w_data;
  assign op_ready   = !r_res_valid || res_ready;
  assign w_acc      = op_valid && op_ready;
  assign w_in_range = {1'b0, op_sel} < (SELW+1)'(NREGS);
  assign w_cur      = w_in_range ? r_regs[op_sel] : '0;
  reg_arith_alu #(.WIDTH(WIDTH), .OFFW(OFFW), .ZERO_OFF(ZERO_OFF)) u_alu (
    .i_code (op_code),
    .i_cur  (w_cur),
    .i_v    (op_v),
    .i_pc   (op_data),
    .o_we   (w_we),
    .o_next (w_next),
    .o_data (w_data),
    .o_taken(w_taken),
    .o_zero (w_zero),
    .o_flag (w_flag)
  );
  // Accepting edge writes the target counter and loads the result buffer; an out-of-range select only raises the flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_sel   <= '0;
      r_res_taken <= 1'b0;
      r_res_zero  <= 1'b0;
      r_res_flag  <= 1'b0;
    end else if (w_acc) begin
      if (w_in_range && w_we) r_regs[op_sel] <= w_next;
      r_res_valid <= 1'b1;
      r_res_data  <= w_in_range ? w_data : '0;
      r_res_sel   <= op_sel;
      r_res_taken <= w_in_range && w_taken;
      r_res_zero  <= w_in_range && w_zero;
      r_res_flag  <= !w_in_range || w_flag;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_sel   = r_res_sel;
  assign res_taken = r_res_taken;
  assign res_zero  = r_res_zero;
  assign res_flag  = r_res_flag;
endmodule

// File: tb/tb_reg_arith_bank.sv
// tb_reg_arith_bank: directed scenarios plus randomized ops against an integer reference model of the register bank
module tb_reg_arith_bank;
`ifdef REG_ARITH_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic       clk = 1'b0, reset = 1'b1;
  logic       op_valid = 1'b0, op_ready, res_ready = 1'b1;
  logic [2:0] op_code = '0, op_v = '0;
  logic [1:0] op_sel = '0, res_sel;
  logic [7:0] op_data = '0, res_data;
  logic       res_valid, res_taken, res_zero, res_flag;
  int         n_chk = 0, n_pass = 0;
  int         m_regs [4];
  bit         pending = 1'b0;
  logic [13:0] exp_r, held;
  string      exp_tag;

  reg_arith_bank dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_sel(op_sel), .op_v(op_v), .op_data(op_data),
    .res_ready(res_ready), .res_valid(res_valid), .res_data(res_data),
    .res_sel(res_sel), .res_taken(res_taken), .res_zero(res_zero), .res_flag(res_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] obs();
    return {res_valid, res_sel, res_taken, res_zero, res_flag, res_data};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: result beat {valid, sel, taken, zero, flag, data} from the op rules in plain integer arithmetic
  task automatic model(input int c, input int s, input int v, input int d, output logic [13:0] e);
    int cur, nv, r, off;
    bit t, z, f, act;
    cur = m_regs[s]; nv = cur; r = 0; t = 0; f = 0; act = 1;
    case (c)
      1: begin
        if (SAT && cur == 255) f = 1;
        else begin nv = (cur + 1) % 256; f = (cur + 1) > 255; end
        r = nv;
      end
      2: begin
        if (SAT && cur == 0) f = 1;
        else begin nv = (cur + 255) % 256; f = cur < 1; end
        r = nv;
      end
      3: begin nv = d; r = d; end
      4, 5, 6: begin
        if (c == 6) begin
          if (SAT && cur == 0) f = 1;
          else nv = (cur + 255) % 256;
        end
        t = (c == 4) ? (cur == 0) : (c == 5) ? (cur != 0) : (nv != 0);
        off = (v != 0) ? v : 16;
        r = d + (t ? off : 1);
        f = f | (r > 255);
        r = r % 256;
      end
      default: act = 0;
    endcase
    m_regs[s] = nv;
    z = act && (nv == 0);
    e = {1'b1, 2'(s), t, z, f, 8'(r)};
  endtask

  task automatic check_pending();
    if (pending) check(exp_tag, obs(), exp_r);
    else check("idle_valid", res_valid, 0);
    pending = 0;
  endtask

  task automatic do_op(input string tag, input int c, input int s, input int v, input int d);
    @(negedge clk);
    check_pending();
    op_valid = 1; op_code = 3'(c); op_sel = 2'(s); op_v = 3'(v); op_data = 8'(d); res_ready = 1;
    model(c, s, v, d, exp_r);
    exp_tag = tag;
    pending = 1;
  endtask

  task automatic idle();
    @(negedge clk);
    check_pending();
    op_valid = 0; res_ready = 1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_state", obs(), 14'h0);
    reset = 0;
    #1 check("rst_ready", op_ready, 1);
    do_op("decr_r0", 2, 0, 0, 0);
    do_op("incr_r0", 1, 0, 0, 0);
    idle();
    if (!SAT) begin
      check("b2b_data", res_data, 8'h00);
      check("b2b_zero", res_zero, 1);
    end
    do_op("load_ff", 3, 0, 0, 8'hFF);
    do_op("incr_ff", 1, 0, 0, 0);
    idle();
    check("incr_ff_data", res_data, SAT ? 8'hFF : 8'h00);
    check("incr_ff_flag", res_flag, 1);
    do_op("jizr", 4, 2, 3, 8'hFE);
    idle();
    check("jizr_data", {res_taken, res_flag, res_data}, {2'b11, 8'h01});
    do_op("load_r1", 3, 1, 0, 5);
    for (int i = 0; i < 5; i++) do_op("djnz", 6, 1, 0, 8'h40);
    idle();
    check("djnz_last", {res_taken, res_zero, res_data}, {2'b01, 8'h41});
    do_op("stall_a", 3, 2, 0, 8'h33);
    @(negedge clk);
    check_pending();
    op_valid = 1; op_code = 3'd1; op_sel = 2'd2; op_v = 0; op_data = 8'h00; res_ready = 0;
    held = obs();
    repeat (3) begin
      @(negedge clk);
      check("stall_ready", op_ready, 0);
      check("stall_hold", obs(), held);
    end
    res_ready = 1;
    model(1, 2, 0, 0, exp_r);
    exp_tag = "stall_b";
    pending = 1;
    idle();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) idle();
      else do_op("rand", $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 255));
    end
    do_op("load_r3", 3, 3, 0, 7);
    @(negedge clk);
    check_pending();
    op_valid = 0;
    #2 reset = 1;
    #1 check("rst_mid_valid", res_valid, 0);
    check("rst_mid_out", obs(), 14'h0);
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    pending = 0;
    @(negedge clk);
    reset = 0;
    #1 check("rst_rel_ready", op_ready, 1);
    do_op("jnzr_r3", 5, 3, 1, 8'h10);
    idle();
    check("jnzr_r3_taken", {res_taken, res_data}, {1'b0, 8'h11});
    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
